// File: rtl/dcsformer_pkg.sv
// Shared constants and enumerations for the DCSformer host-side initiator.
// A job is 128 row-major input bytes followed by 8 weight bytes.
package dcsformer_pkg;

   localparam int N_ROW     = 8;
   localparam int N_COL     = 16;
   localparam int N_W       = 8;
   localparam int IN_BYTES  = N_ROW * N_COL;
   localparam int JOB_BYTES = IN_BYTES + N_W;
   localparam int TIMEOUT   = 64;
   localparam int GAP       = 2;
   localparam int AW        = 8;

   typedef enum logic [2:0] {
      LOAD     = 3'd0,
      SEND_I   = 3'd1,
      WAIT_WR  = 3'd2,
      SEND_W   = 3'd3,
      COLLECT  = 3'd4,
      DONE     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_WR_TIMEOUT = 2'd1,
      ERR_OV_TIMEOUT = 2'd2,
      ERR_PROTOCOL   = 2'd3
   } err_code_t;

endpackage

// File: rtl/dcsformer_job_buf.sv
// Job buffer: one synchronous write port, one combinational read port.
// Contents are not reset; a job is always fully rewritten before it is sent.
module dcsformer_job_buf
   import dcsformer_pkg::*;
(
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [JOB_BYTES];

   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < AW'(JOB_BYTES))) mem[wr_addr] <= wr_data;
   end

   assign rd_data = (rd_addr < AW'(JOB_BYTES)) ? mem[rd_addr] : 8'd0;

endmodule

// File: rtl/dcsformer_host.sv
// Initiator side of the DCSformer accelerator link: buffers a job from the
// loader, bursts inputs and weights out, and forwards the 8 result words.
module dcsformer_host
   import dcsformer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   input  logic [7:0]  ld_data,
   output logic        ld_ready,
   output logic        i_valid,
   output logic [7:0]  i_data,
   output logic        w_valid,
   output logic [7:0]  w_data,
   input  logic        w_ready,
   input  logic        o_valid,
   input  logic [31:0] o_data,
   output logic        r_valid,
   output logic [2:0]  r_idx,
   output logic [31:0] r_data,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output state_t      dbg_state
);

   // Loader handshake: a byte transfers on a rising edge where ld_valid && ld_ready;
   // ld_valid may stay high while ld_ready is low and the byte is simply held.
   state_t          state, state_n;
   logic [AW-1:0]   cnt, cnt_n;
   logic [6:0]      tmo, tmo_n;
   logic            err_n, done_n, r_valid_n, buf_we;
   logic [1:0]      code_n;
   logic [2:0]      r_idx_n;
   logic [31:0]     r_data_n;
   logic [AW-1:0]   rd_addr;
   logic [7:0]      rd_data;

   dcsformer_job_buf u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (cnt),
      .wr_data (ld_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Outputs are registered from the next state, so the read address follows cnt_n.
   assign rd_addr = (state_n == SEND_W) ? (cnt_n + AW'(IN_BYTES)) : cnt_n;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      tmo_n     = tmo;
      err_n     = 1'b0;
      code_n    = err_code;
      done_n    = 1'b0;
      r_valid_n = 1'b0;
      r_idx_n   = 3'd0;
      r_data_n  = 32'd0;
      buf_we    = 1'b0;
      case (state)
         LOAD: begin
            if (ld_valid && ld_ready) begin
               buf_we = 1'b1;
               if (cnt == AW'(JOB_BYTES - 1)) begin
                  state_n = SEND_I;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         SEND_I: begin
            if (w_ready) begin
               err_n   = 1'b1;
               code_n  = ERR_PROTOCOL;
               state_n = LOAD;
               cnt_n   = '0;
            end else if (cnt == AW'(IN_BYTES - 1)) begin
               state_n = WAIT_WR;
               cnt_n   = '0;
               tmo_n   = 7'd1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_WR: begin
            // tmo counts idle cycles including the current one.
            if (w_ready) begin
               state_n = SEND_W;
               cnt_n   = '0;
            end else if (tmo == 7'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               code_n  = ERR_WR_TIMEOUT;
               state_n = LOAD;
               cnt_n   = '0;
            end else begin
               tmo_n = tmo + 1'b1;
            end
         end
         SEND_W: begin
            if (o_valid) begin
               err_n   = 1'b1;
               code_n  = ERR_PROTOCOL;
               state_n = LOAD;
               cnt_n   = '0;
            end else if (cnt == AW'(N_W - 1)) begin
               state_n = COLLECT;
               cnt_n   = '0;
               tmo_n   = 7'd1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         COLLECT: begin
            if (o_valid) begin
               r_valid_n = 1'b1;
               r_idx_n   = cnt[2:0];
               r_data_n  = o_data;
               if (cnt == AW'(N_W - 1)) begin
                  done_n  = 1'b1;
                  state_n = DONE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else if (cnt != '0) begin
               err_n   = 1'b1;
               code_n  = ERR_PROTOCOL;
               state_n = LOAD;
               cnt_n   = '0;
            end else if (tmo == 7'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               code_n  = ERR_OV_TIMEOUT;
               state_n = LOAD;
               cnt_n   = '0;
            end else begin
               tmo_n = tmo + 1'b1;
            end
         end
         DONE: begin
            if (cnt == AW'(GAP - 1)) begin
               state_n = LOAD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = LOAD;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= LOAD;
         cnt      <= '0;
         tmo      <= '0;
         ld_ready <= 1'b0;
         i_valid  <= 1'b0;
         i_data   <= 8'd0;
         w_valid  <= 1'b0;
         w_data   <= 8'd0;
         r_valid  <= 1'b0;
         r_idx    <= 3'd0;
         r_data   <= 32'd0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         tmo      <= tmo_n;
         ld_ready <= (state_n == LOAD);
         i_valid  <= (state_n == SEND_I);
         i_data   <= (state_n == SEND_I) ? rd_data : 8'd0;
         w_valid  <= (state_n == SEND_W);
         w_data   <= (state_n == SEND_W) ? rd_data : 8'd0;
         r_valid  <= r_valid_n;
         r_idx    <= r_idx_n;
         r_data   <= r_data_n;
         done     <= done_n;
         err      <= err_n;
         err_code <= code_n;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_dcsformer_host.sv
// Bench for dcsformer_host: loader driver, accelerator model, scoreboard monitor.
module tb_dcsformer_host;
   import dcsformer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_ready;
   logic        i_valid;
   logic [7:0]  i_data;
   logic        w_valid;
   logic [7:0]  w_data;
   logic        w_ready;
   logic        o_valid;
   logic [31:0] o_data;
   logic        r_valid;
   logic [2:0]  r_idx;
   logic [31:0] r_data;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   state_t      dbg_state;

   dcsformer_host dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .w_valid   (w_valid),
      .w_data    (w_data),
      .w_ready   (w_ready),
      .o_valid   (o_valid),
      .o_data    (o_data),
      .r_valid   (r_valid),
      .r_idx     (r_idx),
      .r_data    (r_data),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Toy kernel: column j weighted by row sums, scaled by weight j.
   function automatic logic [31:0] kernel(input logic [7:0] in_b[IN_BYTES],
                                          input logic [7:0] w_b[N_W], input int j);
      logic [31:0] sum, rs;
      sum = 32'd0;
      for (int i = 0; i < N_ROW; i++) begin
         rs = 32'd0;
         for (int c = 0; c < N_COL; c++) rs += {24'd0, in_b[i*N_COL + c]};
         sum += {24'd0, in_b[i*N_COL + j]} * rs;
      end
      return sum * {24'd0, w_b[j]};
   endfunction

   // ---------------- scoreboard ----------------
   logic [7:0]  exp_i_q[$];
   logic [7:0]  exp_w_q[$];
   logic [34:0] exp_r_q[$];
   logic [7:0]  job_b[2*JOB_BYTES];

   task automatic push_job(input int base, input int n_r, input bit w_too);
      logic [7:0] t_in[IN_BYTES];
      logic [7:0] t_w[N_W];
      for (int k = 0; k < IN_BYTES; k++) begin
         t_in[k] = job_b[base + k];
         exp_i_q.push_back(t_in[k]);
      end
      for (int k = 0; k < N_W; k++) begin
         t_w[k] = job_b[base + IN_BYTES + k];
         if (w_too) exp_w_q.push_back(t_w[k]);
      end
      for (int j = 0; j < n_r; j++) exp_r_q.push_back({3'(j), kernel(t_in, t_w, j)});
   endtask

   // ---------------- accelerator model ----------------
   bit          m_wr_en = 1'b1;
   int          m_wr_dly = 5;
   int          m_n_words = 8;
   int          m_phase = 0;
   int          m_cnt = 0;
   int          wr_cyc = 0;
   logic [7:0]  m_in[IN_BYTES];
   logic [7:0]  m_w[N_W];

   initial begin : accel_model
      w_ready = 1'b0;
      o_valid = 1'b0;
      o_data  = 32'd0;
      forever begin
         step();
         w_ready = 1'b0;
         if (!rst_n) begin
            m_phase = 0; m_cnt = 0; o_valid = 1'b0; o_data = 32'd0;
         end else begin
            case (m_phase)
               0: if (i_valid) begin
                     m_in[m_cnt] = i_data;
                     m_cnt++;
                     if (m_cnt == IN_BYTES) begin m_phase = 1; m_cnt = 0; end
                  end
               1: if (i_valid) begin
                     m_in[0] = i_data; m_cnt = 1; m_phase = 0;
                  end else begin
                     m_cnt++;
                     if (m_wr_en && m_cnt == m_wr_dly) begin
                        w_ready = 1'b1; wr_cyc = cyc; m_phase = 2; m_cnt = 0;
                     end
                  end
               2: if (w_valid) begin
                     m_w[m_cnt] = w_data;
                     m_cnt++;
                     if (m_cnt == N_W) begin m_phase = 3; m_cnt = 0; end
                  end
               3: begin
                     m_cnt++;
                     if (m_cnt == 3) begin m_phase = 4; m_cnt = 0; end
                  end
               default: if (m_cnt < m_n_words) begin
                     o_valid = 1'b1; o_data = kernel(m_in, m_w, m_cnt); m_cnt++;
                  end else begin
                     o_valid = 1'b0; o_data = 32'd0; m_phase = 0; m_cnt = 0;
                  end
            endcase
         end
      end
   end

   // ---------------- monitor ----------------
   int n_done = 0;
   int n_err = 0;
   int i_run = 0;
   int w_run = 0;
   int last_i_cyc = 0;
   int done_cyc = 0;
   bit gap_pending = 1'b0;
   bit ld_ready_q = 1'b0;

   initial begin : monitor
      forever begin
         step();
         if (!rst_n) begin
            exp_i_q.delete(); exp_w_q.delete(); exp_r_q.delete();
            i_run = 0; w_run = 0; gap_pending = 1'b0; ld_ready_q = 1'b0;
         end else begin
            if (i_valid) begin
               if (exp_i_q.size() == 0) check("i_extra", 1, 0);
               else check("i_data", i_data, exp_i_q.pop_front());
               i_run++;
               last_i_cyc = cyc;
            end else if (i_run != 0) begin
               check("i_burst_len", i_run, IN_BYTES);
               check("i_data_idle", i_data, 0);
               i_run = 0;
            end
            if (w_valid) begin
               if (w_run == 0) check("w_latency", cyc - wr_cyc, 1);
               if (exp_w_q.size() == 0) check("w_extra", 1, 0);
               else check("w_data", w_data, exp_w_q.pop_front());
               w_run++;
            end else if (w_run != 0) begin
               check("w_burst_len", w_run, N_W);
               w_run = 0;
            end
            if (r_valid) begin
               if (exp_r_q.size() == 0) check("r_extra", 1, 0);
               else check("r_word", {r_idx, r_data}, exp_r_q.pop_front());
            end
            if (done || (r_valid && r_idx == 3'd7))
               check("done_with_r7", done, r_valid && r_idx == 3'd7);
            if (done) begin
               n_done++; done_cyc = cyc; gap_pending = 1'b1;
            end
            if (err) begin
               n_err++;
               check("err_not_done", done, 0);
            end
            if (ld_ready && !ld_ready_q && gap_pending) begin
               check("gap_after_done", cyc - done_cyc, GAP);
               gap_pending = 1'b0;
            end
            ld_ready_q = ld_ready;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_bytes(input int n);
      int k = 0;
      int g = 0;
      logic rdy;
      while (k < n && g < 5000) begin
         ld_valid = 1'b1;
         ld_data  = job_b[k];
         rdy = ld_ready;
         step();
         if (rdy) k++;
         g++;
      end
      ld_valid = 1'b0;
      ld_data  = 8'd0;
      check("load_accepted", k, n);
   endtask

   task automatic wait_done(input string tag);
      int g = 0;
      while (!done && g < 2000) begin step(); g++; end
      check(tag, done, 1);
   endtask

   task automatic wait_err(input string tag);
      int g = 0;
      while (!err && g < 2000) begin step(); g++; end
      check(tag, err, 1);
   endtask

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) job_b[k] = 8'($urandom_range(0, 255));
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'd0;
      repeat (3) step();
      check("rst_ld_ready", ld_ready, 0);
      check("rst_i_valid", i_valid, 0);
      check("rst_w_valid", w_valid, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_state", dbg_state, LOAD);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("ld_ready_up", ld_ready, 1);

      // all-ones job
      for (int k = 0; k < JOB_BYTES; k++) job_b[k] = 8'd1;
      push_job(0, N_W, 1'b1);
      load_bytes(JOB_BYTES);
      wait_done("done_ones");

      // diagonal inputs, weights 1..8
      for (int k = 0; k < IN_BYTES; k++) job_b[k] = ((k % N_COL) == (k / N_COL)) ? 8'd1 : 8'd0;
      for (int k = 0; k < N_W; k++) job_b[IN_BYTES + k] = 8'(k + 1);
      push_job(0, N_W, 1'b1);
      load_bytes(JOB_BYTES);
      wait_done("done_diag");

      // w_ready never arrives
      fill_random(JOB_BYTES);
      m_wr_en = 1'b0;
      push_job(0, 0, 1'b0);
      load_bytes(JOB_BYTES);
      wait_err("err_wr_timeout");
      check("err_code_wr", err_code, ERR_WR_TIMEOUT);
      check("wr_timeout_delay", cyc - last_i_cyc, TIMEOUT);
      step();
      check("ld_ready_after_to", ld_ready, 1);
      check("err_one_cycle", err, 0);
      m_wr_en = 1'b1;

      // only five result words
      fill_random(JOB_BYTES);
      m_n_words = 5;
      push_job(0, 5, 1'b1);
      load_bytes(JOB_BYTES);
      wait_err("err_short");
      check("err_code_short", err_code, ERR_PROTOCOL);
      check("no_done_short", n_done, 2);
      m_n_words = 8;

      // reset at input beat 50
      fill_random(JOB_BYTES);
      push_job(0, N_W, 1'b1);
      load_bytes(JOB_BYTES);
      begin
         int g = 0;
         while (!i_valid && g < 50) begin step(); g++; end
      end
      repeat (50) step();
      check("beat50_valid", i_valid, 1);
      @(negedge clk) rst_n = 1'b0;
      step();
      check("mid_rst_ld_ready", ld_ready, 0);
      check("mid_rst_i_valid", i_valid, 0);
      check("mid_rst_i_data", i_data, 0);
      check("mid_rst_w_valid", w_valid, 0);
      check("mid_rst_r_valid", r_valid, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_err_code", err_code, 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      fill_random(JOB_BYTES);
      push_job(0, N_W, 1'b1);
      load_bytes(JOB_BYTES);
      wait_done("done_after_rst");

      // two jobs back to back, ld_valid held high throughout
      fill_random(2 * JOB_BYTES);
      push_job(0, N_W, 1'b1);
      push_job(JOB_BYTES, N_W, 1'b1);
      load_bytes(2 * JOB_BYTES);
      wait_done("done_b2b");

      repeat (5) step();
      check("i_q_empty", exp_i_q.size(), 0);
      check("w_q_empty", exp_w_q.size(), 0);
      check("r_q_empty", exp_r_q.size(), 0);
      check("n_done", n_done, 5);
      check("n_err", n_err, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
